// File: rtl/line_drawer_core.sv
// line_drawer_core: streams the pixels of a straight line, one per clock, using
// Bresenham stepping. A combinational reduction stage folds every octant into a
// left-to-right, |slope| <= 1 case; the registered stage walks that reduced line.
module line_drawer_core (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic [9:0] x1,
  input  logic [8:0] y1,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       done
);

  // Reduction stage outputs
  logic [9:0]        w_y0_ext;
  logic [9:0]        w_y1_ext;
  logic [9:0]        w_adx;
  logic [9:0]        w_ady;
  logic              w_is_steep;
  logic [9:0]        w_h0;
  logic [9:0]        w_v0;
  logic [9:0]        w_h1;
  logic [9:0]        w_v1;
  logic [9:0]        w_start_h;
  logic [9:0]        w_end_h;
  logic [9:0]        w_start_v;
  logic [9:0]        w_end_v;

  // Slope terms derived from the reduced endpoints
  logic [9:0]        w_dx;
  logic [9:0]        w_dy;
  logic              w_ystep_neg;
  logic signed [11:0] w_err_init;
  logic signed [11:0] w_e;

  // Stepping state
  logic [9:0]        r_cur_h;
  logic [9:0]        r_cur_v;
  logic [9:0]        r_end_h;
  logic [9:0]        r_dx;
  logic [9:0]        r_dy;
  logic              r_ystep_neg;
  logic signed [11:0] r_err;
  logic              r_is_steep;

  // Steep swap, then left-to-right ordering of the two endpoints
  always_comb begin
    w_y0_ext   = {1'b0, y0};
    w_y1_ext   = {1'b0, y1};
    w_adx      = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    w_ady      = (w_y1_ext >= w_y0_ext) ? (w_y1_ext - w_y0_ext) : (w_y0_ext - w_y1_ext);
    w_is_steep = (w_ady > w_adx);

    if (w_is_steep) begin
      w_h0 = w_y0_ext;
      w_v0 = x0;
      w_h1 = w_y1_ext;
      w_v1 = x1;
    end else begin
      w_h0 = x0;
      w_v0 = w_y0_ext;
      w_h1 = x1;
      w_v1 = w_y1_ext;
    end

    if (w_h0 > w_h1) begin
      w_start_h = w_h1;
      w_start_v = w_v1;
      w_end_h   = w_h0;
      w_end_v   = w_v0;
    end else begin
      w_start_h = w_h0;
      w_start_v = w_v0;
      w_end_h   = w_h1;
      w_end_v   = w_v1;
    end
  end

  // Load-time slope terms and the per-step error candidate
  always_comb begin
    w_dx        = w_end_h - w_start_h;
    w_dy        = (w_end_v >= w_start_v) ? (w_end_v - w_start_v) : (w_start_v - w_end_v);
    w_ystep_neg = !(w_end_v > w_start_v);
    w_err_init  = 12'sd0 - $signed({3'b000, w_dx[9:1]});
    w_e         = r_err + $signed({2'b00, r_dy});
  end

  // Bresenham stepping; set always wins and restarts from the new start pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_h     <= '0;
      r_cur_v     <= '0;
      r_end_h     <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_ystep_neg <= 1'b0;
      r_err       <= '0;
      r_is_steep  <= 1'b0;
    end else if (set) begin
      r_cur_h     <= w_start_h;
      r_cur_v     <= w_start_v;
      r_end_h     <= w_end_h;
      r_dx        <= w_dx;
      r_dy        <= w_dy;
      r_ystep_neg <= w_ystep_neg;
      r_err       <= w_err_init;
      r_is_steep  <= w_is_steep;
    end else if (r_cur_h != r_end_h) begin
      r_cur_h <= r_cur_h + 10'd1;
      if (w_e >= 0) begin
        r_cur_v <= r_ystep_neg ? (r_cur_v - 10'd1) : (r_cur_v + 10'd1);
        r_err   <= w_e - $signed({2'b00, r_dx});
      end else begin
        r_err   <= w_e;
      end
    end
  end

  // Undo the steep swap on the way out; done follows the state directly
  always_comb begin
    if (r_is_steep) begin
      x = r_cur_v;
      y = r_cur_h[8:0];
    end else begin
      x = r_cur_h;
      y = r_cur_v[8:0];
    end
    done = (r_cur_h == r_end_h);
  end

endmodule

// File: tb/tb_line_drawer_core.sv
// Directed bench for line_drawer_core: table of lines with hand-computed pixel
// sequences, plus hand-written mid-line set, held set and async reset cases.
module tb_line_drawer_core;

  logic       clk;
  logic       reset;
  logic       set;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [9:0] x1;
  logic [8:0] y1;
  logic [9:0] x;
  logic [8:0] y;
  logic       done;

  int n_checks;
  int n_fail;

  line_drawer_core dut (
    .clk   (clk),
    .reset (reset),
    .set   (set),
    .x0    (x0),
    .y0    (y0),
    .x1    (x1),
    .y1    (y1),
    .x     (x),
    .y     (y),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]       ax0;
    logic [8:0]       ay0;
    logic [9:0]       ax1;
    logic [8:0]       ay1;
    int               n;
    logic [5:0][9:0]  ex;
    logic [5:0][8:0]  ey;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [5:0][9:0] px(input int a, b, c, d, e, f);
    logic [5:0][9:0] r;
    r[0] = 10'(a); r[1] = 10'(b); r[2] = 10'(c);
    r[3] = 10'(d); r[4] = 10'(e); r[5] = 10'(f);
    return r;
  endfunction

  function automatic logic [5:0][8:0] py(input int a, b, c, d, e, f);
    logic [5:0][8:0] r;
    r[0] = 9'(a); r[1] = 9'(b); r[2] = 9'(c);
    r[3] = 9'(d); r[4] = 9'(e); r[5] = 9'(f);
    return r;
  endfunction

  // One-cycle set pulse; endpoints are scrambled afterwards to show they are not resampled
  task automatic start(input int ax0, input int ay0, input int ax1, input int ay1);
    @(negedge clk);
    x0  = 10'(ax0);
    y0  = 9'(ay0);
    x1  = 10'(ax1);
    y1  = 9'(ay1);
    set = 1'b1;
    @(posedge clk);
    #1;
    set = 1'b0;
    x0  = 10'($urandom_range(0, 639));
    y0  = 9'($urandom_range(0, 479));
    x1  = 10'($urandom_range(0, 639));
    y1  = 9'($urandom_range(0, 479));
  endtask

  task automatic expect_seq(input string nm, input int n, input logic [5:0][9:0] ex,
                            input logic [5:0][8:0] ey);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s px%0d x", nm, i), int'(x), int'(ex[i]));
      chk($sformatf("%s px%0d y", nm, i), int'(y), int'(ey[i]));
      chk($sformatf("%s px%0d done", nm, i), int'(done), (i == n - 1) ? 1 : 0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("%s hold%0d x", nm, k), int'(x), int'(ex[n-1]));
      chk($sformatf("%s hold%0d y", nm, k), int'(y), int'(ey[n-1]));
      chk($sformatf("%s hold%0d done", nm, k), int'(done), 1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set      = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;

    vecs[0] = '{10'd1, 9'd1, 10'd6, 9'd1, 6, px(1, 2, 3, 4, 5, 6), py(1, 1, 1, 1, 1, 1)};
    vecs[1] = '{10'd6, 9'd1, 10'd1, 9'd1, 6, px(1, 2, 3, 4, 5, 6), py(1, 1, 1, 1, 1, 1)};
    vecs[2] = '{10'd1, 9'd1, 10'd1, 9'd6, 6, px(1, 1, 1, 1, 1, 1), py(1, 2, 3, 4, 5, 6)};
    vecs[3] = '{10'd1, 9'd6, 10'd1, 9'd1, 6, px(1, 1, 1, 1, 1, 1), py(1, 2, 3, 4, 5, 6)};
    vecs[4] = '{10'd1, 9'd1, 10'd6, 9'd3, 6, px(1, 2, 3, 4, 5, 6), py(1, 2, 2, 2, 3, 3)};
    vecs[5] = '{10'd6, 9'd3, 10'd1, 9'd1, 6, px(1, 2, 3, 4, 5, 6), py(1, 2, 2, 2, 3, 3)};
    vecs[6] = '{10'd1, 9'd1, 10'd3, 9'd6, 6, px(1, 2, 2, 2, 3, 3), py(1, 2, 3, 4, 5, 6)};
    vecs[7] = '{10'd3, 9'd6, 10'd1, 9'd1, 6, px(1, 2, 2, 2, 3, 3), py(1, 2, 3, 4, 5, 6)};
    vecs[8] = '{10'd1, 9'd1, 10'd1, 9'd1, 1, px(1, 0, 0, 0, 0, 0), py(1, 0, 0, 0, 0, 0)};

    // Reset state
    #12;
    chk("reset x", int'(x), 0);
    chk("reset y", int'(y), 0);
    chk("reset done", int'(done), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle done", int'(done), 1);

    // Table-driven lines
    for (int v = 0; v < 9; v++) begin
      start(int'(vecs[v].ax0), int'(vecs[v].ay0), int'(vecs[v].ax1), int'(vecs[v].ay1));
      expect_seq($sformatf("vec%0d", v), vecs[v].n, vecs[v].ex, vecs[v].ey);
    end

    // set mid-line aborts and restarts with the new endpoints
    start(1, 1, 6, 1);
    @(negedge clk);
    chk("abort px0 x", int'(x), 1);
    @(negedge clk);
    chk("abort px1 x", int'(x), 2);
    chk("abort px1 done", int'(done), 0);
    start(1, 6, 1, 1);
    expect_seq("restart", 6, px(1, 1, 1, 1, 1, 1), py(1, 2, 3, 4, 5, 6));

    // set held high keeps reloading the start pixel
    @(negedge clk);
    x0 = 10'd1; y0 = 9'd1; x1 = 10'd6; y1 = 9'd3;
    set = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("held%0d x", k), int'(x), 1);
      chk($sformatf("held%0d y", k), int'(y), 1);
      chk($sformatf("held%0d done", k), int'(done), 0);
    end
    set = 1'b0;
    @(negedge clk);
    chk("held release x", int'(x), 2);
    chk("held release y", int'(y), 2);

    // Asynchronous reset mid-line takes effect before the next edge
    start(1, 1, 6, 3);
    @(negedge clk);
    chk("prereset x", int'(x), 1);
    @(negedge clk);
    chk("prereset y", int'(y), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset x", int'(x), 0);
    chk("async reset y", int'(y), 0);
    chk("async reset done", int'(done), 1);
    @(negedge clk);
    reset = 1'b0;
    start(5, 7, 5, 7);
    expect_seq("post reset point", 1, px(5, 0, 0, 0, 0, 0), py(7, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
